// File: rtl/run_gen.sv
// Run-length bit generator: emits N ones and a terminating zero, and
// tracks a Gray-coded 8-ones detector alongside the stream.
`timescale 1ns/1ps
module run_gen #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             len_valid,
  input  logic [LEN_W-1:0] len_data,
  input  logic             abort,
  output logic             len_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic [2:0]       gray_state,
  output logic             exp_pulse,
  output logic             done,
  output logic [4:0]       run_pulses
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ONES = 2'd1;
  localparam logic [1:0] ZERO = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gray_q, gray_d;
  logic [4:0]       pul_q, pul_d;
  logic             bit_q, bit_d;
  logic             vld_q, vld_d;
  logic             exp_q, exp_d;
  logic             done_q, done_d;
  logic             accept;

  function automatic logic [2:0] gray_inc(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    b = b + 3'd1;
    return b ^ (b >> 1);
  endfunction

  assign len_ready = (state_q == IDLE);
  assign accept    = len_valid & len_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          if (len_data != '0) begin
            state_d = ONES;
            cnt_d   = len_data;
          end else begin
            state_d = ZERO;
          end
        end
      end
      (state_q == ONES): begin
        cnt_d = cnt_q - 1'b1;
        if (abort || cnt_q == LEN_W'(1))
          state_d = ZERO;
      end
      (state_q == ZERO): begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Detector advances on the bit currently on the output
  always_comb begin
    gray_d = gray_q;
    if (vld_q && bit_q)
      gray_d = gray_inc(gray_q);
    else if (vld_q)
      gray_d = 3'b000;
  end

  always_comb begin
    pul_d = pul_q;
    if (accept)
      pul_d = '0;
    else if (exp_q)
      pul_d = pul_q + 5'd1;
  end

  assign vld_d  = (state_d != IDLE);
  assign bit_d  = (state_d == ONES);
  assign done_d = (state_d == ZERO);
  assign exp_d  = bit_d & (gray_d == 3'b100);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= 3'b000;
      pul_q   <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      exp_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      pul_q   <= pul_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
    end
  end

  assign out_bit    = bit_q;
  assign out_valid  = vld_q;
  assign gray_state = gray_q;
  assign exp_pulse  = exp_q;
  assign done       = done_q;
  assign run_pulses = pul_q;

endmodule

// File: tb/tb_run_gen.sv
// Bench for run_gen: vector table, corner sequences and random runs
// checked against a run-level model of the stream.
`timescale 1ns/1ps
module tb_run_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       len_valid = 1'b0;
  logic [7:0] len_data = 8'd0;
  logic       abort = 1'b0;
  logic       len_ready, out_bit, out_valid;
  logic       exp_pulse, done;
  logic [2:0] gray_state;
  logic [4:0] run_pulses;

  int tests = 0;
  int fails = 0;

  int gseq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  typedef struct {
    int len;
    int ab;
    bit hold;
    int e_ones;
    int e_pul;
  } vec_t;

  vec_t vt [10];

  run_gen #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .len_valid(len_valid), .len_data(len_data),
    .abort(abort), .len_ready(len_ready),
    .out_bit(out_bit), .out_valid(out_valid),
    .gray_state(gray_state), .exp_pulse(exp_pulse),
    .done(done), .run_pulses(run_pulses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run: n ones (fewer if aborted) then a single zero
  task automatic run(input int L, input int ab, input bit hold,
                     output int ones, output int pul);
    int n;
    n = (ab > 0 && ab < L) ? ab : L;
    ones = 0;
    pul = -1;
    chk($sformatf("L%0d ready_pre", L), len_ready, 1);
    len_data = L[7:0];
    len_valid = 1'b1;
    step();
    if (hold) begin
      len_data = 8'd2;
    end else begin
      len_valid = 1'b0;
      len_data = 8'($urandom);
    end
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("L%0d k%0d valid", L, k), out_valid, 1);
      chk($sformatf("L%0d k%0d bit", L, k), out_bit, 1);
      chk($sformatf("L%0d k%0d gray", L, k), gray_state,
          gseq[(k-1)%8]);
      chk($sformatf("L%0d k%0d exp", L, k), exp_pulse,
          (k % 8 == 0) ? 1 : 0);
      chk($sformatf("L%0d k%0d done", L, k), done, 0);
      chk($sformatf("L%0d k%0d ready", L, k), len_ready, 0);
      if (out_bit) ones++;
      if (k == ab) abort = 1'b1;
      step();
      abort = 1'b0;
    end
    chk($sformatf("L%0d term valid", L), out_valid, 1);
    chk($sformatf("L%0d term bit", L), out_bit, 0);
    chk($sformatf("L%0d term gray", L), gray_state, gseq[n%8]);
    chk($sformatf("L%0d term exp", L), exp_pulse, 0);
    chk($sformatf("L%0d term done", L), done, 1);
    chk($sformatf("L%0d term pulses", L), run_pulses, n / 8);
    pul = run_pulses;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk($sformatf("L%0d idle ready", L), len_ready, 1);
    chk($sformatf("L%0d idle valid", L), out_valid, 0);
    chk($sformatf("L%0d idle done", L), done, 0);
    chk($sformatf("L%0d idle gray", L), gray_state, 0);
    if (hold) begin
      step();
      chk($sformatf("L%0d hold accept", L), out_valid, 1);
      chk($sformatf("L%0d hold bit", L), out_bit, 1);
      len_valid = 1'b0;
      for (int c = 0; c < 10 && !done; c++) step();
      chk($sformatf("L%0d hold done", L), done, 1);
      step();
    end
  endtask

  initial begin
    int ones, pul, L, ab;
    vt[0] = '{3, 0, 1'b0, 3, 0};
    vt[1] = '{8, 0, 1'b0, 8, 1};
    vt[2] = '{17, 0, 1'b0, 17, 2};
    vt[3] = '{0, 0, 1'b0, 0, 0};
    vt[4] = '{20, 5, 1'b1, 5, 0};
    vt[5] = '{255, 0, 1'b0, 255, 31};
    vt[6] = '{16, 16, 1'b0, 16, 2};
    vt[7] = '{1, 0, 1'b0, 1, 0};
    vt[8] = '{9, 1, 1'b0, 1, 0};
    vt[9] = '{24, 0, 1'b1, 24, 3};

    len_valid = 1'b1;
    len_data = 8'd5;
    #12;
    chk("rst ready", len_ready, 1);
    chk("rst valid", out_valid, 0);
    chk("rst bit", out_bit, 0);
    chk("rst gray", gray_state, 0);
    chk("rst exp", exp_pulse, 0);
    chk("rst done", done, 0);
    chk("rst pulses", run_pulses, 0);
    len_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run(vt[i].len, vt[i].ab, vt[i].hold, ones, pul);
      chk($sformatf("vec%0d ones", i), ones, vt[i].e_ones);
      chk($sformatf("vec%0d pulses", i), pul, vt[i].e_pul);
    end

    // Reset during the 10th one of a 40-long run
    len_data = 8'd40;
    len_valid = 1'b1;
    step();
    len_valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("mid bit", out_bit, 1);
    chk("mid gray", gray_state, gseq[1]);
    chk("mid pulses", run_pulses, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", out_valid, 0);
    chk("mid rst ready", len_ready, 1);
    chk("mid rst gray", gray_state, 0);
    chk("mid rst done", done, 0);
    chk("mid rst pulses", run_pulses, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post rst done%0d", k), done, 0);
      chk($sformatf("post rst valid%0d", k), out_valid, 0);
    end
    run(8, 0, 1'b0, ones, pul);
    chk("post rst ones", ones, 8);

    for (int r = 0; r < 25; r++) begin
      L = int'($urandom_range(0, 60));
      ab = 0;
      if (L > 0 && $urandom_range(0, 2) == 0)
        ab = int'($urandom_range(1, L));
      run(L, ab, 1'b0, ones, pul);
      chk($sformatf("rnd%0d ones", r), ones,
          (ab > 0) ? ab : L);
      for (int w = int'($urandom_range(0, 2)); w > 0; w--)
        step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
